mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing one single-ported program/data memory (16 x 32) between two GPP-style masters, e.g. two cores, or a core plus a program loader.
- Each requester presents the same Addr/RW/En style bus the cores already use. The arbiter serialises accesses, drives the memory port, and returns read data with a one-cycle Valid strobe.
- Arbitration is round-robin, with one outstanding transaction at a time.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from MEn to MRData valid; legal range 1..7.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- Req0  input  1  requester 0 access request; held until Valid0.
- Addr0  input  ADDR_W  requester 0 address.
- RW0  input  1  requester 0 direction, 0 = read, 1 = write.
- WData0  input  DATA_W  requester 0 write data.
- Gnt0  output  1  one-cycle pulse: requester 0 transaction issued.
- Valid0  output  1  one-cycle pulse: requester 0 transaction complete.
- Req1, Addr1, RW1, WData1, Gnt1, Valid1: same as the port 0 signals, for requester 1.
- RData  output  DATA_W  read data; meaningful while Valid0 or Valid1 is high.
- MAddr  output  ADDR_W  memory address.
- MRW  output  1  memory direction.
- MEn  output  1  memory enable.
- MWData  output  DATA_W  memory write data.
- MRData  input  DATA_W  memory read data.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-high.
  - On Rst, all outputs are 0, State = S_idle, last-granted pointer Last = 1 (port 0 wins the first tie), latency counter = 0.
  - Reset asserted mid-transaction aborts immediately: MEn drops asynchronously and no Valid is produced.
- States: S_idle, S_issue, S_wait, S_resp.
- S_idle:
  - Samples Req0/Req1 at the clock edge.
  - If none is asserted, stay in S_idle.
  - If one is asserted, it wins.
  - If both are asserted, the port not equal to Last wins.
  - Latch the winner's Addr/RW/WData and the winner id into internal registers, then go to S_issue.
- S_issue:
  - Exactly one cycle.
  - MEn = 1; MAddr/MRW/MWData driven from the latched registers.
  - Gnt of the winner = 1.
  - Load the latency counter with MEM_LAT, then go to S_wait.
- S_wait:
  - MEn = 0; count down each cycle.
  - When the count reaches 1 and the access is a read, capture MRData into RData at that edge, then go to S_resp.
  - Writes also pass through S_wait, giving uniform timing.
- S_resp:
  - Exactly one cycle.
  - Valid of the winner = 1; Last = winner.
  - On a write, RData keeps its previous value.
  - Then go to S_idle.
- Timing:
  - If Req is sampled at edge e: Gnt/MEn in cycle e+1, Valid in cycle e+2+MEM_LAT.
  - Throughput is one transaction per MEM_LAT+3 cycles.
- Request rules:
  - Req is sampled only in S_idle.
  - Dropping Req after Gnt does not cancel the transaction.
  - A requester must deassert Req in the cycle after its Valid, or it is treated as a new request.
- Outputs: all outputs are registered; Gnt0/Gnt1 and Valid0/Valid1 are never high simultaneously.
- Starvation bound: with both requests held continuously, grants strictly alternate 0, 1, 0, 1, ...
- Address width: addresses are not range-checked; ADDR_W bits are passed through unchanged.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds outputs Cnt0 and Cnt1 (16 bits each).
  - Each counter increments on its port's Gnt pulse and saturates at 16'hFFFF.
  - Cleared by Rst.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single read, MEM_LAT=1: Req0=1, Addr0=4'h2, RW0=0, memory holds 32'h2002_0005 at address 2 -> Gnt0 1 cycle after sampling, MEn=1 with MAddr=2, Valid0 at e+3, RData=32'h2002_0005.
- Simultaneous contention: Req0=Req1=1 held for 4 transactions -> grant order 0, 1, 0, 1; each Valid is 4 cycles apart; no overlap of Gnt or Valid.
- Write then read: port 1 writes 32'hDEAD_BEEF to address 7, then reads address 7 -> MRW=1 and MWData=32'hDEAD_BEEF during the issue cycle; the read returns 32'hDEAD_BEEF, and RData is unchanged at the write's Valid1.
- Latency parameter: MEM_LAT=3, single read of address 0 -> Valid0 at e+5, and RData is captured from MRData exactly 3 cycles after MEn.
- Reset mid-operation: assert Rst during S_wait -> MEn, Gnt, Valid and RData go to 0 at once; after release, simultaneous Req0/Req1 grant port 0 first.
- With ARB_STATS_EN: 3 port-0 grants and 2 port-1 grants -> Cnt0=3, Cnt1=2; preload near 16'hFFFF and confirm saturation.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for a single-ported memory
//
// Purpose: serialises accesses from two Addr/RW/En style masters onto one
// memory port. One transaction is outstanding at a time. Read data comes back
// with a one-cycle Valid strobe.
//
// Ports:
//   Clk, Rst               clock (rising edge), asynchronous active-high reset
//   Req0/Addr0/RW0/WData0  requester 0 request bus (RW 0 = read, 1 = write)
//   Gnt0, Valid0           requester 0 issue pulse, completion pulse
//   Req1/Addr1/RW1/WData1  requester 1 request bus
//   Gnt1, Valid1           requester 1 issue pulse, completion pulse
//   RData                  read data, meaningful while Valid0 or Valid1 is high
//   MAddr/MRW/MEn/MWData   memory port, driven during the issue cycle only
//   MRData                 memory read data, valid MEM_LAT cycles after MEn
//   Cnt0, Cnt1             saturating grant counters (only with ARB_STATS_EN)
//
// Build option: define ARB_STATS_EN to add the Cnt0/Cnt1 grant counters.
module mem_port_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic              RW0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Gnt0,
  output logic              Valid0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic              RW1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt1,
  output logic              Valid1,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] MAddr,
  output logic              MRW,
  output logic              MEn,
  output logic [DATA_W-1:0] MWData,
  input  logic [DATA_W-1:0] MRData
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       Cnt0,
  output logic [15:0]       Cnt1
`endif
);

  typedef enum logic [1:0] {S_idle, S_issue, S_wait, S_resp} state_t;

  state_t     state, state_n;
  logic       last;       // port granted most recently; the other one wins a tie
  logic       win_id, win_n;
  logic       lat_rw;
  logic [2:0] lat_cnt;
  logic       take;       // idle with a request: latch the winner this edge
  logic       cap;        // last wait cycle of a read: capture MRData this edge
  logic       gnt0_n, gnt1_n, valid0_n, valid1_n, men_n;

  always_comb begin
    state_n  = state;
    win_n    = win_id;
    take     = 1'b0;
    cap      = 1'b0;
    case (state)
      S_idle: begin
        if (Req0 || Req1) begin
          take    = 1'b1;
          win_n   = (Req0 && Req1) ? ~last : Req1;
          state_n = S_issue;
        end
      end
      S_issue: state_n = S_wait;
      S_wait: begin
        if (lat_cnt == 3'd1) begin
          cap     = ~lat_rw;
          state_n = S_resp;
        end
      end
      S_resp:  state_n = S_idle;
      default: state_n = S_idle;
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    men_n    = (state_n == S_issue);
    gnt0_n   = men_n & ~win_n;
    gnt1_n   = men_n & win_n;
    valid0_n = (state_n == S_resp) & ~win_n;
    valid1_n = (state_n == S_resp) & win_n;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= S_idle;
      last    <= 1'b1;
      win_id  <= 1'b0;
      lat_rw  <= 1'b0;
      lat_cnt <= 3'd0;
      Gnt0    <= 1'b0;
      Gnt1    <= 1'b0;
      Valid0  <= 1'b0;
      Valid1  <= 1'b0;
      RData   <= '0;
      MAddr   <= '0;
      MRW     <= 1'b0;
      MEn     <= 1'b0;
      MWData  <= '0;
    end else begin
      state  <= state_n;
      Gnt0   <= gnt0_n;
      Gnt1   <= gnt1_n;
      Valid0 <= valid0_n;
      Valid1 <= valid1_n;
      MEn    <= men_n;
      // The memory-port registers double as the latched request; they hold
      // the winner's bus for the issue cycle and are cleared afterwards.
      if (take) begin
        win_id <= win_n;
        lat_rw <= win_n ? RW1 : RW0;
        MAddr  <= win_n ? Addr1 : Addr0;
        MRW    <= win_n ? RW1 : RW0;
        MWData <= win_n ? WData1 : WData0;
      end else if (state == S_issue) begin
        MAddr  <= '0;
        MRW    <= 1'b0;
        MWData <= '0;
      end
      if (state == S_issue)
        lat_cnt <= 3'(MEM_LAT);
      else if (state == S_wait)
        lat_cnt <= lat_cnt - 3'd1;
      if (cap)
        RData <= MRData;
      if (state == S_resp)
        last <= win_id;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Cnt0 <= 16'd0;
      Cnt1 <= 16'd0;
    end else begin
      if (gnt0_n && (Cnt0 != 16'hFFFF))
        Cnt0 <= Cnt0 + 16'd1;
      if (gnt1_n && (Cnt1 != 16'hFFFF))
        Cnt1 <= Cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // instance a: MEM_LAT = 1, instance b: MEM_LAT = 3
  logic        rst_a, a_req0, a_rw0, a_req1, a_rw1, a_gnt0, a_gnt1, a_val0, a_val1, a_mrw, a_men;
  logic [3:0]  a_addr0, a_addr1, a_maddr;
  logic [31:0] a_wd0, a_wd1, a_rdata, a_mwd, a_mrd;
  logic        rst_b, b_req0, b_rw0, b_req1, b_rw1, b_gnt0, b_gnt1, b_val0, b_val1, b_mrw, b_men;
  logic [3:0]  b_addr0, b_addr1, b_maddr;
  logic [31:0] b_wd0, b_wd1, b_rdata, b_mwd, b_mrd;
`ifdef ARB_STATS_EN
  logic [15:0] a_cnt0, a_cnt1, b_cnt0, b_cnt1;
`endif

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .Clk(clk), .Rst(rst_a),
    .Req0(a_req0), .Addr0(a_addr0), .RW0(a_rw0), .WData0(a_wd0), .Gnt0(a_gnt0), .Valid0(a_val0),
    .Req1(a_req1), .Addr1(a_addr1), .RW1(a_rw1), .WData1(a_wd1), .Gnt1(a_gnt1), .Valid1(a_val1),
    .RData(a_rdata), .MAddr(a_maddr), .MRW(a_mrw), .MEn(a_men), .MWData(a_mwd), .MRData(a_mrd)
`ifdef ARB_STATS_EN
    , .Cnt0(a_cnt0), .Cnt1(a_cnt1)
`endif
  );

  mem_port_arbiter #(.ADDR_W(4), .DATA_W(32), .MEM_LAT(3)) dut_b (
    .Clk(clk), .Rst(rst_b),
    .Req0(b_req0), .Addr0(b_addr0), .RW0(b_rw0), .WData0(b_wd0), .Gnt0(b_gnt0), .Valid0(b_val0),
    .Req1(b_req1), .Addr1(b_addr1), .RW1(b_rw1), .WData1(b_wd1), .Gnt1(b_gnt1), .Valid1(b_val1),
    .RData(b_rdata), .MAddr(b_maddr), .MRW(b_mrw), .MEn(b_men), .MWData(b_mwd), .MRData(b_mrd)
`ifdef ARB_STATS_EN
    , .Cnt0(b_cnt0), .Cnt1(b_cnt1)
`endif
  );

  function automatic logic [31:0] init_val(input logic [31:0] base, input int a);
    return base | (32'(a) << 16) | 32'(2 * a + 1);
  endfunction

  // memory models: read data appears only in the cycle MEM_LAT after MEn,
  // every other cycle carries a cycle-unique junk word
  logic        mem_init;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= init_val(32'h2000_0000, i);
        mem_b[i] <= init_val(32'h3000_0000, i);
      end
    end else begin
      if (a_men && a_mrw) mem_a[a_maddr] <= a_mwd;
      if (b_men && b_mrw) mem_b[b_maddr] <= b_mwd;
    end
    pipe_a    <= (a_men && !a_mrw) ? mem_a[a_maddr] : (32'hBAD0_0000 | 32'(cyc));
    pipe_b[0] <= (b_men && !b_mrw) ? mem_b[b_maddr] : (32'hBAD1_0000 | 32'(cyc));
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign a_mrd = pipe_a;
  assign b_mrd = pipe_b[2];

  // scoreboard
  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        ea, eb;
  logic [31:0] ref_a [16];
  logic [31:0] ref_b [16];
  logic [31:0] model_rd_a, model_rd_b;

  always @(negedge clk) begin
    if (a_val0 || a_val1) begin
      tests++;
      if (q_a.size() == 0) begin
        fails++;
        $display("FAIL sb_a_unexpected valid0=%b valid1=%b required none", a_val0, a_val1);
      end else begin
        ea = q_a.pop_front();
        if ({a_val1, a_val0, a_rdata} !== {ea.port, ~ea.port, ea.data}) begin
          fails++;
          $display("FAIL sb_a valid1/valid0=%b%b rdata=%h required %b%b %h",
                   a_val1, a_val0, a_rdata, ea.port, ~ea.port, ea.data);
        end
      end
    end
    if (b_val0 || b_val1) begin
      tests++;
      if (q_b.size() == 0) begin
        fails++;
        $display("FAIL sb_b_unexpected valid0=%b valid1=%b required none", b_val0, b_val1);
      end else begin
        eb = q_b.pop_front();
        if ({b_val1, b_val0, b_rdata} !== {eb.port, ~eb.port, eb.data}) begin
          fails++;
          $display("FAIL sb_b valid1/valid0=%b%b rdata=%h required %b%b %h",
                   b_val1, b_val0, b_rdata, eb.port, ~eb.port, eb.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; mem_init = 1'b1;
    {a_req0, a_rw0, a_req1, a_rw1, a_addr0, a_addr1, a_wd0, a_wd1} = '0;
    {b_req0, b_rw0, b_req1, b_rw1, b_addr0, b_addr1, b_wd0, b_wd1} = '0;
    for (int i = 0; i < 16; i++) begin
      ref_a[i] = init_val(32'h2000_0000, i);
      ref_b[i] = init_val(32'h3000_0000, i);
    end
    model_rd_a = '0; model_rd_b = '0;
    repeat (3) tick;
    tests++;
    if ({a_gnt0, a_gnt1, a_val0, a_val1, a_men, a_mrw, a_maddr, a_mwd, a_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_a outputs gnt=%b%b val=%b%b men=%b rdata=%h required all 0",
               a_gnt0, a_gnt1, a_val0, a_val1, a_men, a_rdata);
    end
    tests++;
    if ({b_gnt0, b_gnt1, b_val0, b_val1, b_men, b_mrw, b_maddr, b_mwd, b_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_b outputs gnt=%b%b val=%b%b men=%b rdata=%h required all 0",
               b_gnt0, b_gnt1, b_val0, b_val1, b_men, b_rdata);
    end
    mem_init = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    tick;
  endtask

  task automatic test_contention;
    int   g = 0;
    int   nv = 0;
    int   lastv = 0;
    logic ovl = 1'b0;
    logic done = 1'b0;
    a_addr0 = 4'h1; a_addr1 = 4'h3; a_rw0 = 1'b0; a_rw1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea.port = i[0];
      ea.data = i[0] ? ref_a[3] : ref_a[1];
      q_a.push_back(ea);
    end
    model_rd_a = ref_a[3];
    a_req0 = 1'b1; a_req1 = 1'b1;
    for (int t = 0; t < 80 && !done; t++) begin
      tick;
      if ((a_gnt0 && a_gnt1) || (a_val0 && a_val1)) ovl = 1'b1;
      if (a_gnt0 || a_gnt1) begin
        tests++;
        if (a_gnt1 !== (g % 2 == 1)) begin
          fails++;
          $display("FAIL contention_order grant %0d went to port %b required %0d", g, a_gnt1, g % 2);
        end
        g++;
        if (g == 4) begin a_req0 = 1'b0; a_req1 = 1'b0; end
      end
      if (a_val0 || a_val1) begin
        if (nv > 0) begin
          tests++;
          if (cyc - lastv !== 4) begin
            fails++;
            $display("FAIL contention_spacing valid gap %0d required 4", cyc - lastv);
          end
        end
        lastv = cyc;
        nv++;
        if (nv == 4) done = 1'b1;
      end
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL contention_timeout valids seen %0d required 4", nv);
    end
    tests++;
    if (ovl !== 1'b0) begin
      fails++;
      $display("FAIL contention_overlap overlap=%b required 0", ovl);
    end
    tick;
  endtask

  task automatic test_single_read;
    int p;
    int tg = -1;
    int tv = -1;
    ea.port = 1'b0; ea.data = ref_a[2]; q_a.push_back(ea); model_rd_a = ref_a[2];
    a_addr0 = 4'h2; a_rw0 = 1'b0; a_req0 = 1'b1;
    p = cyc;
    for (int t = 0; t < 20 && tv < 0; t++) begin
      tick;
      if (a_gnt0 && tg < 0) begin
        tg = cyc;
        a_req0 = 1'b0;
        tests++;
        if ({a_men, a_maddr, a_mrw} !== {1'b1, 4'h2, 1'b0}) begin
          fails++;
          $display("FAIL read_issue men=%b maddr=%h mrw=%b required 1 2 0", a_men, a_maddr, a_mrw);
        end
      end
      if (a_val0) tv = cyc;
    end
    a_req0 = 1'b0;
    tests++;
    if (tg !== p + 1) begin
      fails++;
      $display("FAIL read_gnt_time cycle %0d required %0d", tg, p + 1);
    end
    tests++;
    if (tv !== p + 3) begin
      fails++;
      $display("FAIL read_valid_time cycle %0d required %0d", tv, p + 3);
    end
    tick;
  endtask

  task automatic test_write_read;
    logic got = 1'b0;
    logic issued = 1'b0;
    ea.port = 1'b1; ea.data = model_rd_a; q_a.push_back(ea);
    ref_a[7] = 32'hDEAD_BEEF;
    a_addr1 = 4'h7; a_rw1 = 1'b1; a_wd1 = 32'hDEAD_BEEF; a_req1 = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      tick;
      if (a_gnt1 && !issued) begin
        issued = 1'b1;
        a_req1 = 1'b0;
        tests++;
        if ({a_men, a_maddr, a_mrw, a_mwd} !== {1'b1, 4'h7, 1'b1, 32'hDEAD_BEEF}) begin
          fails++;
          $display("FAIL write_issue men=%b maddr=%h mrw=%b mwdata=%h required 1 7 1 deadbeef",
                   a_men, a_maddr, a_mrw, a_mwd);
        end
      end
      if (a_val1) begin
        got = 1'b1;
        tests++;
        if (a_rdata !== model_rd_a) begin
          fails++;
          $display("FAIL write_rdata_hold rdata=%h required %h", a_rdata, model_rd_a);
        end
      end
    end
    a_req1 = 1'b0;
    tests++;
    if (got !== 1'b1) begin
      fails++;
      $display("FAIL write_timeout valid1=%b required 1", got);
    end
    tick;
    got = 1'b0;
    ea.port = 1'b1; ea.data = 32'hDEAD_BEEF; q_a.push_back(ea); model_rd_a = 32'hDEAD_BEEF;
    a_rw1 = 1'b0; a_wd1 = '0; a_req1 = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      tick;
      if (a_gnt1) a_req1 = 1'b0;
      if (a_val1) got = 1'b1;
    end
    a_req1 = 1'b0;
    tests++;
    if (got !== 1'b1) begin
      fails++;
      $display("FAIL readback_timeout valid1=%b required 1", got);
    end
    tick;
  endtask

  task automatic test_latency;
    int p;
    int tg = -1;
    int tv = -1;
    eb.port = 1'b0; eb.data = ref_b[0]; q_b.push_back(eb); model_rd_b = ref_b[0];
    b_addr0 = 4'h0; b_rw0 = 1'b0; b_req0 = 1'b1;
    p = cyc;
    for (int t = 0; t < 30 && tv < 0; t++) begin
      tick;
      if (b_gnt0 && tg < 0) begin
        tg = cyc;
        b_req0 = 1'b0;
        tests++;
        if ({b_men, b_maddr} !== {1'b1, 4'h0}) begin
          fails++;
          $display("FAIL lat3_issue men=%b maddr=%h required 1 0", b_men, b_maddr);
        end
      end
      if (b_val0) tv = cyc;
    end
    b_req0 = 1'b0;
    tests++;
    if (tg !== p + 1) begin
      fails++;
      $display("FAIL lat3_gnt_time cycle %0d required %0d", tg, p + 1);
    end
    tests++;
    if (tv !== p + 5) begin
      fails++;
      $display("FAIL lat3_valid_time cycle %0d required %0d", tv, p + 5);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    logic issued = 1'b0;
    logic saw_v = 1'b0;
    logic first = 1'b1;
    int   nv = 0;
    ea.port = 1'b0; ea.data = ref_a[2]; q_a.push_back(ea);
    a_addr0 = 4'h2; a_rw0 = 1'b0; a_req0 = 1'b1;
    for (int t = 0; t < 10 && !issued; t++) begin
      tick;
      if (a_gnt0) issued = 1'b1;
    end
    a_req0 = 1'b0;
    tests++;
    if (issued !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_issue_timeout gnt0=%b required 1", issued);
    end
    tick;  // now in the wait cycle
    rst_a = 1'b1;
    #1;
    tests++;
    if ({a_men, a_gnt0, a_gnt1, a_val0, a_val1, a_rdata} !== '0) begin
      fails++;
      $display("FAIL rstmid_async men=%b gnt=%b%b val=%b%b rdata=%h required all 0",
               a_men, a_gnt0, a_gnt1, a_val0, a_val1, a_rdata);
    end
    q_a.delete();
    model_rd_a = '0;
    tick; tick;
    rst_a = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick;
      if (a_val0 || a_val1) saw_v = 1'b1;
    end
    tests++;
    if (saw_v !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_no_valid valid seen=%b required 0", saw_v);
    end
    ea.port = 1'b0; ea.data = ref_a[4]; q_a.push_back(ea);
    ea.port = 1'b1; ea.data = ref_a[5]; q_a.push_back(ea);
    model_rd_a = ref_a[5];
    a_addr0 = 4'h4; a_addr1 = 4'h5; a_rw0 = 1'b0; a_rw1 = 1'b0;
    a_req0 = 1'b1; a_req1 = 1'b1;
    for (int t = 0; t < 30 && nv < 2; t++) begin
      tick;
      if ((a_gnt0 || a_gnt1) && first) begin
        first = 1'b0;
        tests++;
        if ({a_gnt1, a_gnt0} !== 2'b01) begin
          fails++;
          $display("FAIL rstmid_first_grant gnt1/gnt0=%b%b required 01", a_gnt1, a_gnt0);
        end
      end
      if (a_gnt0) a_req0 = 1'b0;
      if (a_gnt1) a_req1 = 1'b0;
      if (a_val0 || a_val1) nv++;
    end
    a_req0 = 1'b0; a_req1 = 1'b0;
    tests++;
    if (nv !== 2) begin
      fails++;
      $display("FAIL rstmid_timeout valids %0d required 2", nv);
    end
    tick;
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats;
    // dut_a has one grant per port since its last reset
    for (int i = 0; i < 3; i++) begin
      logic pt;
      logic got;
      pt = (i == 2);
      got = 1'b0;
      ea.port = pt; ea.data = ref_a[6]; q_a.push_back(ea); model_rd_a = ref_a[6];
      a_addr0 = 4'h6; a_addr1 = 4'h6; a_rw0 = 1'b0; a_rw1 = 1'b0;
      if (pt) a_req1 = 1'b1; else a_req0 = 1'b1;
      for (int t = 0; t < 20 && !got; t++) begin
        tick;
        if (a_gnt0 || a_gnt1) begin a_req0 = 1'b0; a_req1 = 1'b0; end
        if (a_val0 || a_val1) got = 1'b1;
      end
      a_req0 = 1'b0; a_req1 = 1'b0;
      tests++;
      if (got !== 1'b1) begin
        fails++;
        $display("FAIL stats_timeout transaction %0d valid=%b required 1", i, got);
      end
      tick;
    end
    tests++;
    if ({a_cnt0, a_cnt1} !== {16'd3, 16'd2}) begin
      fails++;
      $display("FAIL stats_a cnt0=%0d cnt1=%0d required 3 2", a_cnt0, a_cnt1);
    end
    tests++;
    if ({b_cnt0, b_cnt1} !== {16'd1, 16'd0}) begin
      fails++;
      $display("FAIL stats_b cnt0=%0d cnt1=%0d required 1 0", b_cnt0, b_cnt1);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_contention;
    test_single_read;
    test_write_read;
    test_latency;
    test_reset_mid;
`ifdef ARB_STATS_EN
    test_stats;
`endif
    repeat (3) tick;
    tests++;
    if (q_a.size() + q_b.size() !== 0) begin
      fails++;
      $display("FAIL sb_leftover pending %0d required 0", q_a.size() + q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
